nn_weight_loader: RTL and testbench
===================================

Name: nn_weight_loader

Overview:
- Upstream stage of the three-layer perceptron network.
- Accepts a serial stream of Width-bit weights over a valid/ready handshake and loads them into shadow registers in layer order (L1, then L2, then L3).
- On stream completion, commits all weights atomically onto the network's wg1/wg2/wg3 buses, so the network never sees a partially updated weight set.

Parameters:
- numInput, 5, inputs per layer-1 perceptron; also sets the packing pitch of the wg buses.
- Width, 8, bits per weight.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load sequence; honoured only in IDLE.
- s_data  input  Width  weight word.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader can accept a word.
- wg1  output  Width*numInput*3  layer-1 weights; neuron i, input j at bits (i*numInput+j)*Width.
- wg2  output  Width*numInput*4  layer-2 weights; neuron i, input j (j<3) at bits (i*3+j)*Width; unused upper bits are 0.
- wg3  output  Width*numInput  layer-3 weights; input j (j<4) at bits j*Width; unused upper bits are 0.
- weights_valid  output  1  at least one full set has been committed.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on commit.
- err  output  1  checksum mismatch flag; only driven when WLOAD_CHECKSUM_EN is defined, otherwise tied 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - wg1, wg2, wg3, shadow registers, counters, weights_valid, done, err and s_ready all go to 0.
  - Reset in the middle of a load discards the partial load; no commit occurs.
- A word transfers when s_valid and s_ready are both high at a clk edge.
- s_ready is combinational from state and is high only in LOAD_L1, LOAD_L2, LOAD_L3 and CHECK.
- State machine:
  - IDLE: start=1 moves to LOAD_L1; word index clears to 0.
  - LOAD_L1: each accepted word is written to shadow1[idx] and idx increments. After word 3*numInput-1, move to LOAD_L2 and clear idx.
  - LOAD_L2: 12 words (4 neurons x 3 inputs), then move to LOAD_L3.
  - LOAD_L3: 4 words, then move to COMMIT (or to CHECK when the macro is defined).
  - COMMIT: lasts one cycle. Shadow registers are copied to wg1/2/3, done=1 and weights_valid=1, then return to IDLE.
- Latency: the wg outputs update at the clock edge one cycle after the edge that accepted the final word.
- An idle s_valid (low) stalls the loader indefinitely with no timeout.
- start is ignored when busy=1. start and s_valid arriving together in IDLE: no word is accepted in that cycle.
- Between commits the wg outputs hold their previous values. A second load fully replaces the committed set.
- Shadow words are stored unmodified; no arithmetic on weights.
- Total words per load: 3*numInput + 16 (31 at the defaults).

Optional Feature:
- Macro: WLOAD_CHECKSUM_EN.
- Defined:
  - After LOAD_L3 the loader enters CHECK and accepts one extra word.
  - That word is compared with the running sum of all weight words, truncated mod 2^Width.
  - Match: go to COMMIT and clear err.
  - Mismatch: set err=1, discard the shadow set (no commit, no done, wg outputs unchanged), return to IDLE.
  - err holds until the next start or rst.
- Undefined: no CHECK state, no checksum word, err is constant 0.

Decomposition:
- Shared package nn_pkg:
  - State enumeration type (IDLE, LOAD_L1, LOAD_L2, LOAD_L3, CHECK, COMMIT).
  - Constants L1_NEURONS=3, L2_NEURONS=4, L2_INPUTS=3, L3_INPUTS=4.
  - Function computing total word count from numInput.
- One sub-module: nn_weight_bank. It is a parameterised shadow/active register bank (depth, Width, pad width) with a write port (we, addr, data) and a commit strobe. It is instantiated three times, one per layer.

Test Plan:
- Reset then idle: assert rst 2 cycles, hold start=0 -> all wg=0, weights_valid=0, s_ready=0, busy=0.
- Full load, continuous valid: start, then stream words 1..31 -> done pulses exactly one cycle after word 31 is accepted; wg1 word0=1, word14=15; wg2 word0=16, word11=27, upper 64 bits 0; wg3 word0=28, word3=31.
- Back-pressure and gaps: toggle s_valid every other cycle -> same final packing; no word skipped or duplicated; wg stable until the commit edge.
- Reset mid-load: rst after word 10 of a second load -> wg outputs cleared to 0, weights_valid=0, state IDLE; a new start plus 31 words loads correctly.
- Start ignored while busy: pulse start at word 5 -> sequence unaffected, only one done.
- WLOAD_CHECKSUM_EN: words all 0x09, checksum 0x17 (31*9 mod 256) -> commit; checksum 0x18 -> err=1, no done, wg unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the perceptron weight loader
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_L1 = 3'd1,
        LOAD_L2 = 3'd2,
        LOAD_L3 = 3'd3,
        CHECK   = 3'd4,
        COMMIT  = 3'd5
    } state_e;

    localparam int L1_NEURONS = 3;
    localparam int L2_NEURONS = 4;
    localparam int L2_INPUTS  = 3;
    localparam int L3_INPUTS  = 4;

    // Weight words in one full load, excluding any checksum word.
    function automatic int total_words(input int num_input);
        return L1_NEURONS * num_input + L2_NEURONS * L2_INPUTS + L3_INPUTS;
    endfunction

endpackage

// File: rtl/nn_weight_bank.sv
// rtl/nn_weight_bank.sv - shadow/active register bank with atomic commit
module nn_weight_bank #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter int PAD    = 0,
    parameter int ADDR_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [WIDTH-1:0]            data,
    input  logic                        commit,
    output logic [DEPTH*WIDTH+PAD-1:0]  active
);

    logic [WIDTH-1:0]       shadow_q [DEPTH];
    logic [WIDTH-1:0]       shadow_d [DEPTH];
    logic [DEPTH*WIDTH-1:0] active_q;
    logic [DEPTH*WIDTH-1:0] active_d;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (addr == ADDR_W'(i))) begin
                shadow_d[i] = data;
            end
        end
    end

    // Commit copies the shadow contents as they stood before this edge.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_d[i*WIDTH +: WIDTH] = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    generate
        if (PAD > 0) begin : g_pad
            assign active = {{PAD{1'b0}}, active_q};
        end else begin : g_nopad
            assign active = active_q;
        end
    endgenerate

endmodule

// File: rtl/nn_weight_loader.sv
// rtl/nn_weight_loader.sv - streams weights into shadow banks and commits them atomically
// Optional trailing checksum word when WLOAD_CHECKSUM_EN is defined.
module nn_weight_loader
    import nn_pkg::*;
#(
    parameter int numInput = 5,
    parameter int Width    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [Width-1:0]             s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [Width*numInput*3-1:0]  wg1,
    output logic [Width*numInput*4-1:0]  wg2,
    output logic [Width*numInput-1:0]    wg3,
    output logic                         weights_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int L1_WORDS = L1_NEURONS * numInput;
    localparam int L2_WORDS = L2_NEURONS * L2_INPUTS;
    localparam int L3_WORDS = L3_INPUTS;
    localparam int IDX_W    = $clog2(total_words(numInput));
    localparam int WG2_PAD  = Width * numInput * 4 - Width * L2_WORDS;
    localparam int WG3_PAD  = Width * numInput - Width * L3_WORDS;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             weights_valid_q, weights_valid_d;
    logic             done_q, done_d;
    logic             we1, we2, we3, commit;
    logic             xfer;

`ifdef WLOAD_CHECKSUM_EN
    logic [Width-1:0] sum_q, sum_d;
    logic             err_q, err_d;
`endif

    assign xfer = s_valid && s_ready;

    always_comb begin
        s_ready = (state_q == LOAD_L1) || (state_q == LOAD_L2) ||
                  (state_q == LOAD_L3) || (state_q == CHECK);
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        weights_valid_d = weights_valid_q;
        done_d          = 1'b0;
        we1             = 1'b0;
        we2             = 1'b0;
        we3             = 1'b0;
        commit          = 1'b0;
`ifdef WLOAD_CHECKSUM_EN
        sum_d           = sum_q;
        err_d           = err_q;
        if (xfer && (state_q != CHECK)) begin
            sum_d = sum_q + s_data;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_L1;
                    idx_d   = '0;
`ifdef WLOAD_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD_L1: begin
                if (xfer) begin
                    we1 = 1'b1;
                    if (idx_q == IDX_W'(L1_WORDS - 1)) begin
                        state_d = LOAD_L2;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_L2: begin
                if (xfer) begin
                    we2 = 1'b1;
                    if (idx_q == IDX_W'(L2_WORDS - 1)) begin
                        state_d = LOAD_L3;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_L3: begin
                if (xfer) begin
                    we3 = 1'b1;
                    if (idx_q == IDX_W'(L3_WORDS - 1)) begin
`ifdef WLOAD_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = COMMIT;
`endif
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
`ifdef WLOAD_CHECKSUM_EN
                if (xfer) begin
                    if (s_data == sum_q) begin
                        state_d = COMMIT;
                        err_d   = 1'b0;
                    end else begin
                        // Bad set is abandoned; the next load overwrites the shadows.
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                commit          = 1'b1;
                done_d          = 1'b1;
                weights_valid_d = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            weights_valid_q <= 1'b0;
            done_q          <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
            sum_q           <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            weights_valid_q <= weights_valid_d;
            done_q          <= done_d;
`ifdef WLOAD_CHECKSUM_EN
            sum_q           <= sum_d;
            err_q           <= err_d;
`endif
        end
    end

    assign weights_valid = weights_valid_q;
    assign done          = done_q;
    assign busy          = (state_q != IDLE);
`ifdef WLOAD_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

    nn_weight_bank #(
        .DEPTH(L1_WORDS), .WIDTH(Width), .PAD(0), .ADDR_W(IDX_W)
    ) u_bank_l1 (
        .clk(clk), .rst(rst), .we(we1), .addr(idx_q), .data(s_data),
        .commit(commit), .active(wg1)
    );

    nn_weight_bank #(
        .DEPTH(L2_WORDS), .WIDTH(Width), .PAD(WG2_PAD), .ADDR_W(IDX_W)
    ) u_bank_l2 (
        .clk(clk), .rst(rst), .we(we2), .addr(idx_q), .data(s_data),
        .commit(commit), .active(wg2)
    );

    nn_weight_bank #(
        .DEPTH(L3_WORDS), .WIDTH(Width), .PAD(WG3_PAD), .ADDR_W(IDX_W)
    ) u_bank_l3 (
        .clk(clk), .rst(rst), .we(we3), .addr(idx_q), .data(s_data),
        .commit(commit), .active(wg3)
    );

endmodule

// File: tb/tb_nn_weight_loader.sv
// tb/tb_nn_weight_loader.sv - self-checking bench for nn_weight_loader
module tb_nn_weight_loader;

    localparam int N     = 5;
    localparam int W     = 8;
    localparam int NW    = 3 * N + 16;
    localparam int WG1_W = W * N * 3;
    localparam int WG2_W = W * N * 4;
    localparam int WG3_W = W * N;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WG1_W-1:0] wg1;
    logic [WG2_W-1:0] wg2;
    logic [WG3_W-1:0] wg3;
    logic             weights_valid;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    logic [W-1:0]     words [NW];
    logic [WG1_W-1:0] cur1;
    logic [WG2_W-1:0] cur2;
    logic [WG3_W-1:0] cur3;

    nn_weight_loader #(.numInput(N), .Width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .wg1(wg1), .wg2(wg2), .wg3(wg3),
        .weights_valid(weights_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference packing: words fill L1, then L2, then L3 in stream order.
    task automatic pack_expected(output logic [WG1_W-1:0] e1, output logic [WG2_W-1:0] e2,
                                 output logic [WG3_W-1:0] e3);
        e1 = '0;
        e2 = '0;
        e3 = '0;
        for (int k = 0; k < NW; k++) begin
            if (k < 3 * N)           e1[k*W +: W] = words[k];
            else if (k < 3 * N + 12) e2[(k-3*N)*W +: W] = words[k];
            else                     e3[(k-3*N-12)*W +: W] = words[k];
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, output bit ok);
        bit acc;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 200; n++) begin
            acc = s_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%0h s_ready never rose", d);
        end
    endtask

    task automatic run_load(input string tag, input bit gaps, input int extra_start_at,
                            input logic [W-1:0] ck_delta);
        logic [WG1_W-1:0] e1;
        logic [WG2_W-1:0] e2;
        logic [WG3_W-1:0] e3;
        bit ok;
        int d0;
        int sum;
        d0 = done_seen;
        sum = 0;
        pack_expected(e1, e2, e3);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy busy=%b s_ready=%b expected 1 1", tag, busy, s_ready);
        end
        for (int k = 0; k < NW; k++) begin
            if (gaps && (k % 2 == 1)) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                step();
                checks++;
                if (wg1 !== cur1 || wg2 !== cur2 || wg3 !== cur3) begin
                    errors++;
                    $display("FAIL %s_stable k=%0d wg1=%h expected %h", tag, k, wg1, cur1);
                end
            end
            if (k == extra_start_at) start = 1'b1;
            sum += int'(words[k]);
            send_word(words[k], ok);
            start = 1'b0;
        end
`ifdef WLOAD_CHECKSUM_EN
        send_word(W'(sum) + ck_delta, ok);
`endif
        checks++;
        if (done !== 1'b0 || wg1 !== cur1 || wg2 !== cur2 || wg3 !== cur3) begin
            errors++;
            $display("FAIL %s_precommit done=%b wg1=%h expected done 0 wg1 %h", tag, done, wg1, cur1);
        end
        step();
        if (ck_delta == '0) begin
            checks++;
            if (done !== 1'b1 || weights_valid !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s_done done=%b wv=%b err=%b expected 1 1 0", tag, done, weights_valid, err);
            end
            checks++;
            if (wg1 !== e1 || wg2 !== e2 || wg3 !== e3) begin
                errors++;
                $display("FAIL %s_pack wg1=%h wg2=%h wg3=%h expected %h %h %h", tag, wg1, wg2, wg3, e1, e2, e3);
            end
            cur1 = e1;
            cur2 = e2;
            cur3 = e3;
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || (done_seen - d0) != 1) begin
                errors++;
                $display("FAIL %s_one_done done=%b busy=%b pulses=%0d expected 0 0 1", tag, done, busy, done_seen - d0);
            end
        end else begin
            step();
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || (done_seen - d0) != 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_ck_bad err=%b done=%b pulses=%0d busy=%b expected 1 0 0 0", tag, err, done, done_seen - d0, busy);
            end
            checks++;
            if (wg1 !== cur1 || wg2 !== cur2 || wg3 !== cur3) begin
                errors++;
                $display("FAIL %s_ck_hold wg1=%h expected %h", tag, wg1, cur1);
            end
        end
    endtask

    task automatic randomize_words;
        for (int k = 0; k < NW; k++) words[k] = W'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        step();
        step();
        checks++;
        if (wg1 !== '0 || wg2 !== '0 || wg3 !== '0 || weights_valid !== 1'b0 ||
            s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset wv=%b s_ready=%b busy=%b done=%b err=%b expected all 0", weights_valid, s_ready, busy, done, err);
        end
        rst = 1'b0;
        cur1 = '0;
        cur2 = '0;
        cur3 = '0;
        step();
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle busy=%b s_ready=%b expected 0 0", busy, s_ready);
        end
    endtask

    task automatic test_full_load;
        for (int k = 0; k < NW; k++) words[k] = W'(k + 1);
        run_load("full", 1'b0, -1, '0);
        checks++;
        if (wg1[0 +: W] !== 8'd1 || wg1[14*W +: W] !== 8'd15 || wg2[0 +: W] !== 8'd16 ||
            wg2[11*W +: W] !== 8'd27 || wg2[WG2_W-1 -: 64] !== 64'd0 ||
            wg3[0 +: W] !== 8'd28 || wg3[3*W +: W] !== 8'd31 || wg3[WG3_W-1 -: W] !== 8'd0) begin
            errors++;
            $display("FAIL full_fields wg1=%h wg2=%h wg3=%h", wg1, wg2, wg3);
        end
    endtask

    task automatic test_gaps;
        randomize_words();
        run_load("gaps", 1'b1, -1, '0);
    endtask

    task automatic test_start_while_busy;
        randomize_words();
        run_load("busy_start", 1'b0, 5, '0);
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 3; r++) begin
            randomize_words();
            run_load("b2b", ($urandom_range(0, 1) == 1), -1, '0);
        end
    endtask

    task automatic test_reset_mid_load;
        bit ok;
        randomize_words();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) send_word(words[k], ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (wg1 !== '0 || wg2 !== '0 || wg3 !== '0 || weights_valid !== 1'b0 ||
            busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset wv=%b busy=%b s_ready=%b wg1=%h expected zeros", weights_valid, busy, s_ready, wg1);
        end
        cur1 = '0;
        cur2 = '0;
        cur3 = '0;
        randomize_words();
        run_load("after_reset", 1'b0, -1, '0);
    endtask

    task automatic test_idle_start_with_valid;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        step();
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid busy=%b s_ready=%b expected 0 0", busy, s_ready);
        end
        s_valid = 1'b0;
    endtask

`ifdef WLOAD_CHECKSUM_EN
    task automatic test_checksum;
        for (int k = 0; k < NW; k++) words[k] = 8'h09;
        run_load("ck_good", 1'b0, -1, '0);
        randomize_words();
        run_load("ck_bad", 1'b0, -1, 8'h01);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ck_clear err=%b expected 0", err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur1 = '0;
        cur2 = '0;
        cur3 = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_start_with_valid();
        test_full_load();
        test_gaps();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_load();
`ifdef WLOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
